// File: rtl/pdm_seq_ctrl.sv
// Waveform sequencer for the 5-bit PDM core: loads up to DEPTH samples over a
// valid/ready port, then replays them cyclically with a write strobe every div+1 clocks.
module pdm_seq_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       i_cfg_data,
  input  logic             i_cfg_valid,
  input  logic             i_cfg_last,
  output logic             o_cfg_ready,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_clear,
  input  logic [DIV_W-1:0] i_div,
  output logic [4:0]       o_sample_out,
  output logic             o_sample_we,
  output logic             o_playing,
  output logic [AW:0]      o_wave_len
);

  typedef enum logic [1:0] {StIdle, StLoad, StReady, StPlay} state_e;

  state_e           r_state;
  state_e           w_state_d;

  logic [4:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_wave_len;
  logic [DIV_W-1:0] r_div_q;
  logic [DIV_W-1:0] r_cnt;
  logic [4:0]       r_sample_out;
  logic             r_sample_we;
  logic             r_playing;

  logic             w_wr;
  logic             w_full;
  logic             w_rd_wrap;
  logic [AW-1:0]    w_rd_next;
  logic             w_start_play;
  logic             w_mute;

  // clear outranks the write, so a transfer coinciding with clear is dropped
  assign w_wr         = i_cfg_valid & o_cfg_ready & ~i_clear;
  assign w_full       = (r_wr_ptr == AW'(DEPTH - 1));
  assign w_rd_wrap    = ({1'b0, r_rd_ptr} == (r_wave_len - {{AW{1'b0}}, 1'b1}));
  assign w_rd_next    = w_rd_wrap ? '0 : (r_rd_ptr + AW'(1));
  assign w_start_play = (r_state == StReady) & (w_state_d == StPlay);
  assign w_mute       = (r_state == StPlay) & (i_clear | i_stop);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    if (i_clear) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle, StLoad: begin
          if (w_wr) begin
            w_state_d = (i_cfg_last || w_full) ? StReady : StLoad;
          end
        end
        StReady: begin
          if (i_start) w_state_d = StPlay;
        end
        StPlay: begin
          if (i_stop) w_state_d = StReady;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Output logic
  always_comb begin
    o_cfg_ready = 1'b0;
    unique case (r_state)
      StIdle, StLoad: o_cfg_ready = 1'b1;
      default:        o_cfg_ready = 1'b0;
    endcase
  end

  // Buffer contents are not reset
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_cfg_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_wave_len   <= '0;
      r_div_q      <= '0;
      r_cnt        <= '0;
      r_sample_out <= '0;
      r_sample_we  <= 1'b0;
      r_playing    <= 1'b0;
    end else begin
      r_sample_we <= 1'b0;
      r_playing   <= (w_state_d == StPlay);

      if (i_clear) begin
        r_wr_ptr   <= '0;
        r_wave_len <= '0;
      end else if (w_wr) begin
        r_wr_ptr   <= r_wr_ptr + AW'(1);
        r_wave_len <= r_wave_len + {{AW{1'b0}}, 1'b1};
      end

      if (w_mute) begin
        r_sample_out <= '0;
        r_sample_we  <= 1'b1;
        r_cnt        <= '0;
        r_rd_ptr     <= '0;
      end else if (w_start_play) begin
        r_div_q      <= i_div;
        r_cnt        <= i_div;
        r_rd_ptr     <= '0;
        r_sample_out <= r_mem[0];
        r_sample_we  <= 1'b1;
      end else if (r_state == StPlay) begin
        if (r_cnt == '0) begin
          r_cnt        <= r_div_q;
          r_rd_ptr     <= w_rd_next;
          r_sample_out <= r_mem[w_rd_next];
          r_sample_we  <= 1'b1;
        end else begin
          r_cnt <= r_cnt - DIV_W'(1);
        end
      end
    end
  end

  assign o_sample_out = r_sample_out;
  assign o_sample_we  = r_sample_we;
  assign o_playing    = r_playing;
  assign o_wave_len   = r_wave_len;

endmodule

// File: doc/pdm_seq_ctrl.md
Name: pdm_seq_ctrl

Overview:
Sample sequencer that feeds the 5-bit first-order PDM modulator core. It loads a short waveform, up to DEPTH 5-bit samples, through a valid/ready write port. It then plays the waveform cyclically into the core's input register by pulsing a write strobe every div+1 clocks. It sits between the pin-level interface and the PDM core: sample_out drives the core's pdm_input and sample_we drives its write_en.

Parameters:
DEPTH, 8, number of sample slots in the waveform buffer (power of two, 2..16)
AW, 3, pointer width; AW = log2(DEPTH)
DIV_W, 8, width of the sample-rate divider

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
cfg_data  in  5  sample value to load
cfg_valid  in  1  cfg_data valid
cfg_last  in  1  qualifies cfg_valid; marks the final sample of the waveform
cfg_ready  out  1  buffer accepts a sample this cycle
start  in  1  begin playback (pulse)
stop  in  1  end playback and mute (pulse)
clear  in  1  discard waveform and return to IDLE (pulse)
div  in  DIV_W  sample period minus one, in clk cycles
sample_out  out  5  sample to PDM core input
sample_we  out  1  one-cycle write strobe to PDM core
playing  out  1  high while in PLAY
wave_len  out  AW+1  number of loaded samples (0..DEPTH)

Behaviour:
- Reset values: state IDLE, wr_ptr=0, rd_ptr=0, wave_len=0, sample_out=0, sample_we=0, playing=0, divider counter=0. Buffer contents are don't-care.
- States: IDLE (empty), LOAD (partially filled), READY (waveform complete), PLAY.
- cfg_ready is combinational: 1 in IDLE or LOAD, else 0. It is therefore 1 during reset.
- A write transfer occurs when cfg_valid and cfg_ready are both high on a clk edge: mem[wr_ptr] <= cfg_data, wr_ptr++, wave_len++.
- IDLE -> LOAD on the first transfer without cfg_last.
- IDLE/LOAD -> READY on a transfer with cfg_last, or on the transfer that fills slot DEPTH-1. A full buffer forces READY without cfg_last.
- cfg_valid while cfg_ready=0 is ignored; no write and no error.
- READY + start -> PLAY on the next edge. On that edge:
  - div is latched into div_q; later changes to div are ignored until the next start.
  - rd_ptr=0 and the first sample_we pulse is issued with sample_out=mem[0]. Both are registered, visible the cycle after start is sampled.
- PLAY:
  - The counter loads div_q on each strobe and decrements each cycle. The next strobe fires when the counter is 0.
  - Strobes are therefore exactly div_q+1 cycles apart; div_q=0 gives a strobe every cycle.
  - Each strobe advances rd_ptr and presents mem[rd_ptr]. rd_ptr wraps from wave_len-1 to 0. With wave_len=1 the same sample repeats.
- sample_out holds its value between strobes. sample_we is high for exactly one cycle per strobe.
- PLAY + stop -> READY: on the next edge sample_out=0 and sample_we=1 for one cycle (mute). The counter and rd_ptr are cleared. Waveform and wave_len are retained, so start replays from mem[0].
- clear from any state -> IDLE: wr_ptr=0 and wave_len=0. If clear arrives in PLAY, the same one-cycle mute strobe is issued.
- Priority when pulses coincide: clear > stop > start > write transfer.
  - start in IDLE, LOAD or PLAY is ignored.
  - stop outside PLAY is ignored.
- A start in the same cycle as the cfg_last transfer is ignored; the state is not yet READY.
- playing is registered and equals (state==PLAY).
- Asynchronous reset mid-playback forces all outputs to their reset values immediately. No mute strobe is issued; sample_out=0 is sufficient.

Test Plan:
1. Reset, then load 3 samples 5,17,31 with cfg_last on 31 -> wave_len=3, state READY, cfg_ready=0.
2. Set div=3 and pulse start -> sample_we strobes every 4 cycles carrying 5,17,31,5,17,... The first strobe occurs 1 cycle after start.
3. Load 8 samples 0..7 without cfg_last -> READY after the 8th, cfg_ready drops. A 9th cfg_valid with data 9 is not written; playback shows 0..7 then wraps to 0.
4. During playback (div=0, one strobe per cycle), pulse stop -> next cycle sample_we=1, sample_out=0, then no strobes. A later start restarts at mem[0].
5. Assert clear and stop in the same cycle during PLAY -> state IDLE, wave_len=0, one mute strobe, cfg_ready=1.
6. Change div from 3 to 0 mid-playback -> strobe spacing stays 4 cycles. Assert reset_n low mid-PLAY -> sample_out=0, sample_we=0, playing=0 immediately.
